// File: rtl/disp_pkg.sv
// Shared constants for the display scan decoder: segment patterns, code values, FSM states.
package disp_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 7;
  localparam int unsigned SEG_W_DEF      = 7;
  localparam int unsigned CODE_W         = 5;

  // Active-low patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_UNK   = 5'h1F;

  typedef enum logic [1:0] {IDLE, COLLECT, FRAME, STALL} scan_state_e;

endpackage

// File: rtl/seg7_to_code.sv
// Combinational lookup from an active-low 7-segment pattern back to its character code.
module seg7_to_code
  import disp_pkg::*;
(
  input  logic [SEG_W_DEF-1:0] seg,
  output logic [CODE_W-1:0]    code_c
);

  always_comb begin
    code_c = CODE_UNK;
    case (seg)
      SEG_0:     code_c = 5'h00;
      SEG_1:     code_c = 5'h01;
      SEG_2:     code_c = 5'h02;
      SEG_3:     code_c = 5'h03;
      SEG_4:     code_c = 5'h04;
      SEG_5:     code_c = 5'h05;
      SEG_6:     code_c = 5'h06;
      SEG_7:     code_c = 5'h07;
      SEG_8:     code_c = 5'h08;
      SEG_9:     code_c = 5'h09;
      SEG_A:     code_c = 5'h0A;
      SEG_B:     code_c = 5'h0B;
      SEG_C:     code_c = 5'h0C;
      SEG_D:     code_c = 5'h0D;
      SEG_E:     code_c = 5'h0E;
      SEG_F:     code_c = 5'h0F;
      SEG_BLANK: code_c = CODE_BLANK;
      default:   code_c = CODE_UNK;
    endcase
  end

endmodule

// File: rtl/disp_scan_decoder.sv
// Samples a multiplexed 7-segment scan bus, captures stable digit dwells and assembles frames.
// Define SCAN_TIMEOUT_EN to build the stall timeout counter.
module disp_scan_decoder
  import disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int unsigned SEG_W          = SEG_W_DEF,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS-1:0]        trans,
  input  logic [SEG_W-1:0]             led7seg,
  input  logic                         err_clr,
  output logic                         digit_valid,
  output logic [2:0]                   digit_idx,
  output logic [CODE_W-1:0]            digit_code,
  output logic                         frame_valid,
  output logic [NUM_DIGITS*CODE_W-1:0] frame_codes,
  output logic                         err_multi,
  output logic                         stall
);

  localparam int unsigned SMP_W = NUM_DIGITS + SEG_W;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [SMP_W-1:0]             s_q, s_prev_q;
  logic [CNT_W-1:0]             stab_q, stab_nxt_c;
  logic                         captured_q;
  logic                         same_c, eligible_c, onehot_c, multi_c;
  logic                         capture_c, err_set_c, timeout_c;
  logic [NUM_DIGITS-1:0]        sel_c, seen_q, seen_nxt_c;
  logic [2:0]                   idx_c;
  logic [CODE_W-1:0]            code_c;
  logic [NUM_DIGITS*CODE_W-1:0] codes_q, codes_nxt_c;
  scan_state_e                  state_q, state_nxt_c;

  // Input sampling and dwell stability tracking; one capture per dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= '0;
      s_prev_q   <= '0;
      stab_q     <= '0;
      captured_q <= 1'b0;
    end else begin
      s_q        <= {trans, led7seg};
      s_prev_q   <= s_q;
      stab_q     <= stab_nxt_c;
      captured_q <= same_c ? (captured_q | eligible_c) : eligible_c;
    end
  end

  assign same_c     = (s_q == s_prev_q);
  assign stab_nxt_c = !same_c ? CNT_W'(1) :
                      (stab_q == CNT_W'(SETTLE_CYCLES)) ? stab_q : stab_q + CNT_W'(1);
  assign eligible_c = (stab_nxt_c == CNT_W'(SETTLE_CYCLES)) && !(same_c && captured_q);

  assign sel_c     = s_q[SMP_W-1:SEG_W];
  assign onehot_c  = (sel_c != '0) && ((sel_c & (sel_c - 1'b1)) == '0);
  assign multi_c   = (sel_c != '0) && !onehot_c;
  assign capture_c = eligible_c && onehot_c;
  assign err_set_c = eligible_c && multi_c;

  seg7_to_code u_dec (
    .seg    (s_q[SEG_W-1:0]),
    .code_c (code_c)
  );

  // Select index and the code array as it will look after this capture
  always_comb begin
    idx_c       = '0;
    codes_nxt_c = codes_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_c[i]) idx_c = 3'(i);
      if (capture_c && sel_c[i]) codes_nxt_c[i*CODE_W +: CODE_W] = code_c;
    end
  end

  assign seen_nxt_c = seen_q | (capture_c ? sel_c : '0);

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;

  always_ff @(posedge clk) begin
    if (rst || capture_c)                  to_q <= '0;
    else if (to_q != TO_W'(TIMEOUT_CYCLES)) to_q <= to_q + TO_W'(1);
  end

  // Fires on the edge where the counter reaches the limit, and stays while saturated
  assign timeout_c = !capture_c && (to_q >= TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt_c;
  end

  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      IDLE:    if (capture_c)      state_nxt_c = COLLECT;
               else if (timeout_c) state_nxt_c = STALL;
      COLLECT: if (capture_c && (seen_nxt_c == ALL_SEEN)) state_nxt_c = FRAME;
               else if (timeout_c)                        state_nxt_c = STALL;
      FRAME:   state_nxt_c = COLLECT;
      STALL:   if (capture_c)      state_nxt_c = COLLECT;
      default: state_nxt_c = IDLE;
    endcase
  end

  // Registered outputs and frame assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      digit_code  <= '0;
      frame_valid <= 1'b0;
      frame_codes <= '0;
      err_multi   <= 1'b0;
      stall       <= 1'b0;
      codes_q     <= '0;
      seen_q      <= '0;
    end else begin
      digit_valid <= capture_c;
      if (capture_c) begin
        digit_idx  <= idx_c;
        digit_code <= code_c;
      end
      frame_valid <= (state_nxt_c == FRAME);
      if (state_nxt_c == FRAME) frame_codes <= codes_nxt_c;
      codes_q   <= codes_nxt_c;
      seen_q    <= (state_nxt_c == FRAME) ? '0 : seen_nxt_c;
      err_multi <= err_set_c | (err_multi & ~err_clr);
      stall     <= (state_nxt_c == STALL);
    end
  end

endmodule
